mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 64, address width of every address port.
REQ-002 Parameter: TIMEOUT, default 16, maximum cycles a granted transaction waits for mem_ack.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 if_req  input  1  instruction-fetch request; held until if_ready.
REQ-006 if_addr  input  ADDR_W  fetch byte address, 4-byte aligned.
REQ-007 if_rdata  output  32  fetched instruction.
REQ-008 if_ready  output  1  one-cycle fetch completion pulse.
REQ-009 d_req  input  1  data-access request; held until d_ready.
REQ-010 d_we  input  1  1 = store, 0 = load.
REQ-011 d_addr  input  ADDR_W  data byte address, 8-byte aligned.
REQ-012 d_wdata  input  64  store data.
REQ-013 d_rdata  output  64  load data.
REQ-014 d_ready  output  1  one-cycle data completion pulse.
REQ-015 mem_req  output  1  request to the shared single-port memory.
REQ-016 mem_we  output  1  memory write enable.
REQ-017 mem_addr  output  ADDR_W  memory doubleword address; bits [2:0] are always 0.
REQ-018 mem_wdata  output  64  memory write data.
REQ-019 mem_rdata  input  64  memory read data; valid in the mem_ack cycle.
REQ-020 mem_ack  input  1  memory completion; one cycle.
REQ-021 stall  output  1  pipeline stall indication.
REQ-022 err  output  1  sticky timeout flag.

Function
REQ-023 The FSM SHALL have three states: IDLE, DATA and FETCH.
REQ-024 Grant SHALL occur from IDLE, or in the mem_ack cycle of DATA or FETCH, with no bubble between transactions.
REQ-025 Single pending request: that requester SHALL be granted.
REQ-026 Both requests pending: the requester other than last_grant SHALL be granted; last_grant resets to FETCH, so data wins the first tie.
REQ-027 No request pending: the FSM SHALL enter or stay in IDLE.
REQ-028 On grant, the arbiter SHALL latch the granted address, d_we and d_wdata; mem_req, mem_we, mem_addr and mem_wdata SHALL be registered and valid from the cycle after grant.
REQ-029 mem_req SHALL be 1 exactly while the FSM is in DATA or FETCH.
REQ-030 In FETCH, mem_we SHALL be 0.
REQ-031 On a FETCH ack, the arbiter SHALL register if_rdata as mem_rdata[31:0] when latched addr[2]=0, else mem_rdata[63:32], and pulse if_ready in the following cycle.
REQ-032 On a DATA load ack, the arbiter SHALL register d_rdata as mem_rdata and pulse d_ready in the following cycle.
REQ-033 On a DATA store ack, the arbiter SHALL pulse d_ready in the following cycle, and d_rdata SHALL hold its previous value.
REQ-034 if_rdata and d_rdata SHALL hold their values until the next completion of the same type.
REQ-035 Minimum latency SHALL be 3 cycles: request, then mem_req, then ready (ack in the first mem_req cycle).
REQ-036 stall SHALL be combinational: (if_req & ~if_ready) | (d_req & ~d_ready).
REQ-037 A request SHALL not be re-granted in its own ready cycle, since the requester deasserts req then.
REQ-038 A timeout counter SHALL clear on grant and increment each cycle in DATA or FETCH without mem_ack.
REQ-039 On reaching TIMEOUT-1 without ack, the arbiter SHALL force completion: ready pulse, rdata = 0, err set, return to arbitration.
REQ-040 A mem_ack received in IDLE SHALL be ignored.
REQ-041 Simultaneous mem_ack and timeout SHALL be treated as a normal ack, and err SHALL be unchanged.
REQ-042 err SHALL clear only on reset.

Reset
REQ-043 While rst=0, the arbiter SHALL force: FSM IDLE, last_grant FETCH, counter 0, every output 0 (if_rdata, d_rdata, mem_addr and mem_wdata included).
REQ-044 A reset asserted mid-transaction SHALL drop that transaction with no ready pulse, and the requester SHALL re-request after reset.

Structure
REQ-045 Shared package mem_arb_pkg SHALL hold the state enum (IDLE, DATA, FETCH), the grant enum (GNT_DATA, GNT_FETCH) and the TIMEOUT default constant.
REQ-046 The timeout counter SHALL be one sub-module, mem_arb_timeout, with clear, enable and expired ports.
REQ-047 The remaining FSM, latching and output registers SHALL reside in mem_arbiter.

Verification
REQ-048 Single fetch, if_addr=0x104, ack 2 cycles after mem_req, mem_rdata=0xAAAA_BBBB_1111_2222 -> mem_addr=0x100, if_rdata=0xAAAABBBB, if_ready 1 cycle, stall deasserted after the pulse.
REQ-049 Simultaneous d_req load at 0x2000 and if_req at 0x0 after reset -> DATA granted first, then FETCH granted in the DATA ack cycle, then alternation while both stay asserted.
REQ-050 Store d_addr=0x18, d_wdata=0xDEADBEEF -> mem_we=1, mem_addr=0x18, mem_wdata=0xDEADBEEF, d_ready pulses, d_rdata unchanged.
REQ-051 No mem_ack with TIMEOUT=16 -> d_ready 16 cycles after mem_req rises, d_rdata=0, err=1 and it persists across later good transactions.
REQ-052 rst asserted in the second FETCH cycle -> all outputs 0 immediately; after release, a re-issued if_req completes normally and err=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory arbiter
package mem_arb_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_DATA  = 1'b0,
    GNT_FETCH = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_arb_timeout.sv
// rtl/mem_arb_timeout.sv - saturating wait counter for a granted memory transaction
module mem_arb_timeout
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count waiting cycles and stop at the last value
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter in front of a shared single-port memory
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  output logic [63:0]       d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              err
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(7));

  arb_state_e state_q, state_d;
  grant_e     last_grant_q, last_grant_d;

  logic busy, done, timed_out, expired;
  logic d_elig, if_elig, can_grant;
  logic grant_data, grant_fetch, grant;
  logic [ADDR_W-1:0] sel_addr;

  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [63:0]       mem_wdata_q;
  logic              word_sel_q;
  logic [31:0]       if_rdata_q;
  logic              if_ready_q;
  logic [63:0]       d_rdata_q;
  logic              d_ready_q;
  logic              err_q;

  // Arbitration: decide whether this cycle ends a transaction and who is granted next
  always_comb begin
    busy      = (state_q != IDLE);
    timed_out = busy & expired & ~mem_ack;
    done      = (busy & mem_ack) | timed_out;
    can_grant = ~busy | done;
    // The finishing requester still holds req now and drops it in its ready cycle,
    // so neither of those cycles may hand it a second grant.
    d_elig      = d_req & ~d_ready_q & ~(done & (state_q == DATA));
    if_elig     = if_req & ~if_ready_q & ~(done & (state_q == FETCH));
    grant_data  = can_grant & d_elig & (~if_elig | (last_grant_q == GNT_FETCH));
    grant_fetch = can_grant & if_elig & ~grant_data;
    grant       = grant_data | grant_fetch;
    sel_addr    = grant_data ? d_addr : if_addr;
  end

  // Next state and round-robin pointer
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    if (grant_data) begin
      state_d      = DATA;
      last_grant_d = GNT_DATA;
    end else if (grant_fetch) begin
      state_d      = FETCH;
      last_grant_d = GNT_FETCH;
    end else if (can_grant) begin
      state_d = IDLE;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_FETCH;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Memory-side request registers, loaded at grant so they are valid the next cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      word_sel_q  <= 1'b0;
    end else begin
      mem_req_q <= (state_d != IDLE);
      if (grant) begin
        mem_we_q    <= grant_data & d_we;
        mem_addr_q  <= sel_addr & ALIGN_MASK;
        mem_wdata_q <= grant_data ? d_wdata : 64'd0;
        word_sel_q  <= grant_fetch & if_addr[2];
      end else if (done) begin
        mem_we_q <= 1'b0;
      end
    end
  end

  // Completion: capture read data, pulse ready, remember any forced completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata_q <= '0;
      if_ready_q <= 1'b0;
      d_rdata_q  <= '0;
      d_ready_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if_ready_q <= done & (state_q == FETCH);
      d_ready_q  <= done & (state_q == DATA);
      if (done && (state_q == FETCH)) begin
        if (timed_out) begin
          if_rdata_q <= '0;
        end else begin
          if_rdata_q <= word_sel_q ? mem_rdata[63:32] : mem_rdata[31:0];
        end
      end
      if (done && (state_q == DATA) && (timed_out || !mem_we_q)) begin
        d_rdata_q <= timed_out ? 64'd0 : mem_rdata;
      end
      if (timed_out) begin
        err_q <= 1'b1;
      end
    end
  end

  mem_arb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (grant),
    .enable_i  (busy & ~mem_ack),
    .expired_o (expired)
  );

  // Output drive; stall is held low while reset is asserted
  always_comb begin
    stall     = rst & ((if_req & ~if_ready_q) | (d_req & ~d_ready_q));
    mem_req   = mem_req_q;
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    if_rdata  = if_rdata_q;
    if_ready  = if_ready_q;
    d_rdata   = d_rdata_q;
    d_ready   = d_ready_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [63:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic        err;

  int errors = 0;
  int checks = 0;
  int mcnt = 0;
  int ack_delay = 0;
  bit ack_on = 1'b1;
  bit force_ack = 1'b0;

  mem_arbiter #(
    .ADDR_W  (64),
    .TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stall     (stall),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One cycle: memory responder acks after ack_delay mem_req cycles; requesters drop on ready
  task automatic tick();
    logic prev_ack;
    @(posedge clk);
    #2;
    prev_ack = mem_ack;
    mem_ack = 1'b0;
    if (!mem_req || prev_ack) mcnt = 0;
    if (mem_req && ack_on) begin
      if (mcnt == ack_delay) mem_ack = 1'b1;
      mcnt++;
    end
    if (force_ack) mem_ack = 1'b1;
    if (if_ready) if_req = 1'b0;
    if (d_ready) d_req = 1'b0;
  endtask

  task automatic wait_ready(input bit is_data, input int limit, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (!seen && n < limit) begin
      tick();
      n++;
      if (is_data ? d_ready : if_ready) seen = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    if_req = 1'b0;
    d_req = 1'b0;
    d_we = 1'b0;
    force_ack = 1'b0;
    ack_on = 1'b1;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    tick();
    checks++;
    if ({mem_req, mem_we, if_ready, d_ready, stall, mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b we=%b ifr=%b dr=%b stall=%b addr=%h wdata=%h ifd=%h dd=%h, expected all 0",
               mem_req, mem_we, if_ready, d_ready, stall, mem_addr, mem_wdata, if_rdata, d_rdata);
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_idle_ack();
    tick();
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    tick();
    checks++;
    if ({if_ready, d_ready, mem_req} !== 3'b000) begin
      errors++;
      $display("FAIL idle_ack_ignored: got ifr/dr/req=%b expected 000", {if_ready, d_ready, mem_req});
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL idle_ack_err: got %b expected 0", err); end
  endtask

  task automatic test_single_fetch();
    int n;
    bit seen;
    ack_delay = 2;
    mem_rdata = 64'hAAAA_BBBB_1111_2222;
    tick();
    if_addr = 64'h104;
    if_req = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_on: got %b expected 1", stall); end
    tick();
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL fetch_mem_req: got %b expected 1", mem_req); end
    checks++;
    if (mem_addr !== 64'h100) begin errors++; $display("FAIL fetch_mem_addr: got %h expected 100", mem_addr); end
    checks++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL fetch_mem_we: got %b expected 0", mem_we); end
    wait_ready(1'b0, 40, n, seen);
    checks++;
    if (!seen || n != 3) begin
      errors++;
      $display("FAIL fetch_latency: got seen=%0d cycles=%0d expected seen=1 cycles=3", seen, n);
    end
    checks++;
    if (if_rdata !== 32'hAAAABBBB) begin errors++; $display("FAIL fetch_rdata: got %h expected aaaabbbb", if_rdata); end
    tick();
    checks++;
    if ({if_ready, stall, mem_req} !== 3'b000) begin
      errors++;
      $display("FAIL fetch_after_ready: got ifr/stall/req=%b expected 000", {if_ready, stall, mem_req});
    end
    checks++;
    if (if_rdata !== 32'hAAAABBBB) begin errors++; $display("FAIL fetch_rdata_hold: got %h expected aaaabbbb", if_rdata); end
  endtask

  task automatic test_tie_alternation();
    logic [63:0] got [4];
    logic [63:0] exp_addr [4];
    int ns;
    bit d_re, if_re, prev_req, prev_ack;
    exp_addr[0] = 64'h2000; exp_addr[1] = 64'h0; exp_addr[2] = 64'h2000; exp_addr[3] = 64'h0;
    for (int k = 0; k < 4; k++) got[k] = '1;
    do_reset();
    ack_delay = 1;
    mem_rdata = 64'h0123_4567_89AB_CDEF;
    d_addr = 64'h2000; d_we = 1'b0; d_req = 1'b1;
    if_addr = 64'h0; if_req = 1'b1;
    ns = 0; d_re = 0; if_re = 0; prev_req = 0; prev_ack = 0;
    for (int i = 0; i < 60 && ns < 4; i++) begin
      tick();
      if (mem_req && (!prev_req || prev_ack)) begin
        got[ns] = mem_addr;
        ns++;
      end
      prev_req = mem_req;
      prev_ack = mem_ack;
      if (ns < 4) begin
        if (d_re) begin d_req = 1'b1; d_re = 0; end
        if (if_re) begin if_req = 1'b1; if_re = 0; end
        if (d_ready) d_re = 1;
        if (if_ready) if_re = 1;
      end
    end
    checks++;
    if (ns != 4) begin errors++; $display("FAIL tie_grant_count: got %0d expected 4", ns); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== exp_addr[k]) begin
        errors++;
        $display("FAIL tie_grant_%0d: got addr %h expected %h", k, got[k], exp_addr[k]);
      end
    end
    for (int i = 0; i < 30 && (d_req || if_req); i++) tick();
    checks++;
    if (d_rdata !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL tie_d_rdata: got %h expected 0123456789abcdef", d_rdata); end
    checks++;
    if (if_rdata !== 32'h89AB_CDEF) begin errors++; $display("FAIL tie_if_rdata: got %h expected 89abcdef", if_rdata); end
  endtask

  task automatic test_store();
    int n;
    bit seen;
    do_reset();
    ack_delay = 0;
    mem_rdata = 64'h5555_6666_7777_8888;
    tick();
    d_addr = 64'h8; d_we = 1'b0; d_req = 1'b1;
    wait_ready(1'b1, 40, n, seen);
    checks++;
    if (!seen || n != 2) begin errors++; $display("FAIL load_min_latency: got seen=%0d cycles=%0d expected seen=1 cycles=2", seen, n); end
    checks++;
    if (d_rdata !== 64'h5555_6666_7777_8888) begin errors++; $display("FAIL load_rdata: got %h expected 5555666677778888", d_rdata); end
    tick();
    mem_rdata = 64'h1111_1111_1111_1111;
    d_addr = 64'h18; d_we = 1'b1; d_wdata = 64'hDEADBEEF; d_req = 1'b1;
    tick();
    checks++;
    if ({mem_req, mem_we} !== 2'b11) begin errors++; $display("FAIL store_req_we: got %b expected 11", {mem_req, mem_we}); end
    checks++;
    if (mem_addr !== 64'h18) begin errors++; $display("FAIL store_addr: got %h expected 18", mem_addr); end
    checks++;
    if (mem_wdata !== 64'hDEADBEEF) begin errors++; $display("FAIL store_wdata: got %h expected deadbeef", mem_wdata); end
    wait_ready(1'b1, 40, n, seen);
    checks++;
    if (!seen || n != 1) begin errors++; $display("FAIL store_ready: got seen=%0d cycles=%0d expected seen=1 cycles=1", seen, n); end
    checks++;
    if (d_rdata !== 64'h5555_6666_7777_8888) begin errors++; $display("FAIL store_rdata_hold: got %h expected 5555666677778888", d_rdata); end
    d_we = 1'b0;
    tick();
    checks++;
    if (d_ready !== 1'b0) begin errors++; $display("FAIL store_ready_pulse: got %b expected 0", d_ready); end
  endtask

  task automatic test_timeout();
    int n;
    bit seen;
    do_reset();
    ack_delay = 15;
    mem_rdata = 64'hCAFE_0000_F00D_0001;
    tick();
    d_addr = 64'h40; d_we = 1'b0; d_req = 1'b1;
    tick();
    wait_ready(1'b1, 40, n, seen);
    checks++;
    if (!seen || n != 16) begin errors++; $display("FAIL ack_at_limit_latency: got seen=%0d cycles=%0d expected seen=1 cycles=16", seen, n); end
    checks++;
    if (d_rdata !== 64'hCAFE_0000_F00D_0001 || err !== 1'b0) begin
      errors++;
      $display("FAIL ack_at_limit_normal: got rdata=%h err=%b expected cafe0000f00d0001 err=0", d_rdata, err);
    end
    tick();
    ack_on = 1'b0;
    d_addr = 64'h48; d_req = 1'b1;
    tick();
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL timeout_mem_req: got %b expected 1", mem_req); end
    wait_ready(1'b1, 40, n, seen);
    checks++;
    if (!seen || n != 16) begin errors++; $display("FAIL timeout_latency: got seen=%0d cycles=%0d expected seen=1 cycles=16", seen, n); end
    checks++;
    if (d_rdata !== 64'h0 || err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_result: got rdata=%h err=%b expected 0 err=1", d_rdata, err);
    end
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL timeout_release: got mem_req=%b expected 0", mem_req); end
    ack_on = 1'b1;
    ack_delay = 0;
    mem_rdata = 64'h9999_8888_7777_6666;
    tick();
    if_addr = 64'h0; if_req = 1'b1;
    wait_ready(1'b0, 40, n, seen);
    checks++;
    if (!seen || if_rdata !== 32'h7777_6666) begin
      errors++;
      $display("FAIL post_timeout_fetch: got seen=%0d rdata=%h expected seen=1 rdata=77776666", seen, if_rdata);
    end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
  endtask

  task automatic test_mid_reset();
    int n;
    bit seen;
    bit early;
    ack_delay = 3;
    mem_rdata = 64'h4444_3333_2222_1111;
    tick();
    if_addr = 64'h20; if_req = 1'b1;
    tick();
    tick();
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL midrst_in_fetch: got mem_req=%b expected 1", mem_req); end
    rst = 1'b0;
    if_req = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, if_ready, d_ready, stall, err, mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got req=%b ifr=%b err=%b addr=%h ifd=%h dd=%h expected all 0",
               mem_req, if_ready, err, mem_addr, if_rdata, d_rdata);
    end
    early = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (if_ready || d_ready) early = 1'b1;
    end
    checks++;
    if (early) begin errors++; $display("FAIL midrst_no_ready: got a ready pulse during reset, expected none"); end
    rst = 1'b1;
    tick();
    if_req = 1'b1;
    wait_ready(1'b0, 40, n, seen);
    checks++;
    if (!seen || n != 5) begin errors++; $display("FAIL midrst_reissue: got seen=%0d cycles=%0d expected seen=1 cycles=5", seen, n); end
    checks++;
    if (if_rdata !== 32'h2222_1111 || err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_result: got rdata=%h err=%b expected 22221111 err=0", if_rdata, err);
    end
  endtask

  initial begin
    test_reset();
    test_idle_ack();
    test_single_fetch();
    test_tie_alternation();
    test_store();
    test_timeout();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
